// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: SS.hh BCD stopwatch (00.00-59.99) with edge-triggered start/stop and clear
module bcd_stopwatch #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       wrap
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic          ss_q, clr_q, prev_start_stop, prev_clear;
  logic [PW-1:0] presc;
  logic          ss_edge, clr_edge, tick, c0, c1, c2, c3;
  assign ss_edge  = ss_q & ~prev_start_stop;
  assign clr_edge = clr_q & ~prev_clear;
  assign tick     = running && presc == PW'(TICK_DIV - 1);
  assign c0       = tick && d0 == 4'd9;
  assign c1       = c0 && d1 == 4'd9;
  assign c2       = c1 && d2 == 4'd9;
  assign c3       = c2 && d3 == 4'd5;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ss_q            <= 1'b0;
      clr_q           <= 1'b0;
      prev_start_stop <= 1'b0;
      prev_clear      <= 1'b0;
      running         <= 1'b0;
      wrap            <= 1'b0;
      presc           <= '0;
      d0              <= 4'd0;
      d1              <= 4'd0;
      d2              <= 4'd0;
      d3              <= 4'd0;
    end else begin
      ss_q            <= start_stop;
      clr_q           <= clear;
      prev_start_stop <= ss_q;
      prev_clear      <= clr_q;
      running         <= running ^ ss_edge;
      wrap            <= c3 && !clr_edge;
      // clear wins over a coincident tick; that tick is simply dropped
      if (clr_edge) begin
        presc <= '0;
        d0    <= 4'd0;
        d1    <= 4'd0;
        d2    <= 4'd0;
        d3    <= 4'd0;
      end else begin
        if (running) presc <= tick ? '0 : presc + 1'b1;
        if (tick) d0 <= c0 ? 4'd0 : d0 + 4'd1;
        if (c0) d1 <= c1 ? 4'd0 : d1 + 4'd1;
        if (c1) d2 <= c2 ? 4'd0 : d2 + 4'd1;
        if (c2) d3 <= c3 ? 4'd0 : d3 + 4'd1;
      end
    end
endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Four-digit BCD stopwatch counter that produces the hex nibbles consumed by the seven-segment decoders on the display path. It counts hundredths of a second in SS.hh format (00.00 to 59.99) from a free-running system clock, under start/stop and clear control. Each digit output drives one decoder instance directly. This block is the stage immediately upstream of the display decode.

## Interface

- TICK_DIV, 500000, clock cycles per 0.01 s count (50 MHz clock); legal range >= 2
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start_stop  input  1  synchronous level; each rising edge toggles run state
- clear  input  1  synchronous level; each rising edge zeroes the count
- d0  output  4  hundredths digit, 0-9
- d1  output  4  tenths digit, 0-9
- d2  output  4  seconds units digit, 0-9
- d3  output  4  seconds tens digit, 0-5
- running  output  1  1 while counting
- wrap  output  1  one-cycle pulse on 59.99 -> 00.00

## Operation

- Edge detect:
  - start_stop and clear are each registered once; prev_* holds the last sample.
  - An edge is asserted when in=1 and prev=0.
  - A held-high level produces exactly one edge.
- Run state: 1-bit register, toggled on each start_stop edge. It is the `running` output.
- Prescaler:
  - Counter 0..TICK_DIV-1, width ceil(log2(TICK_DIV)).
  - Advances only while running; holds its value while stopped, so a resumed count keeps its partial interval.
  - tick = running && (prescaler == TICK_DIV-1). On tick, prescaler returns to 0.
- Digit cascade on tick:
  - d0 increments; 9 -> 0 carries into d1.
  - d1: 9 -> 0 carries into d2.
  - d2: 9 -> 0 carries into d3.
  - d3: 5 -> 0 with carry asserts wrap for that one cycle.
  - Digits never hold a non-BCD value (d0-d2 <= 9, d3 <= 5).
- Clear edge:
  - Sets d0..d3 = 0 and prescaler = 0.
  - Does not change run state, so clearing while running keeps counting from 00.00.
  - Clear has priority over a same-cycle tick: that tick is discarded and wrap stays 0.
- Simultaneous start_stop and clear edges: both take effect. Count zeroes and run state toggles.
- Stop edge coinciding with tick: the tick still increments the digits; run goes to 0 the same edge.

## Timing

- Reset values: d0..d3 = 0, running = 0, wrap = 0, prescaler = 0, prev_start_stop = 0, prev_clear = 0.
- Reset is asynchronous. Asserting rst mid-count forces all of the above immediately. The first edge is detected no earlier than the first clock after deassertion.
- Input-to-effect latency: the input is high at clock edge N (edge detect). Run state or count changes are visible after edge N+1.
- After a start edge takes effect, the first d0 increment appears TICK_DIV clocks later.
- wrap is high for exactly one clock, coincident with the digits showing 00.00.
- Outputs are all registered. No combinational path from inputs to outputs.

## Test plan

- Reset: assert rst mid-count at 12.34 -> all digits 0, running=0, wrap=0 immediately, without a clock edge.
- Basic count (TICK_DIV=4): start pulse, run 40 clocks -> d0 counts 0..9, then d1=1 and d0=0 after the 10th tick. Tick spacing is exactly 4 clocks.
- Stop/resume: stop with prescaler=2 at 00.07 and hold 20 clocks -> digits and prescaler frozen. Restart -> next increment occurs 2 clocks after running=1.
- Full wrap (TICK_DIV=2): run 6000 ticks -> 59.99 then 00.00 with wrap=1 for one cycle. d3 never exceeds 5.
- Clear priority: clear edge on the tick cycle at 59.99 -> 00.00, wrap=0, running stays 1. Simultaneous start_stop+clear at 03.21 while running -> 00.00, running=0.
- Held inputs: hold start_stop high for 50 clocks -> exactly one toggle. Hold clear high while running -> a single zeroing, then counting continues.
